// File: rtl/fifo_push_arb.sv
// fifo_push_arb: two-requester round-robin burst arbiter driving a FIFO push port,
// with deferred two-cycle push-side flush.
module fifo_push_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic                  req0_valid_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    input  logic                  req0_last_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    input  logic                  req1_last_i,
    output logic                  req1_ready_o,
    input  logic                  flush_req_i,
    input  logic [3:0]            PUSH_FLAG,
    output logic                  PUSH,
    output logic [DATA_WIDTH-1:0] DIN,
    output logic                  Fifo_Push_Flush,
    output logic [1:0]            grant_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FLUSH} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       last_q, last_d;
    logic       fcnt_q, fcnt_d;
    logic       prev_q;
    logic [1:0] grant_q;
    logic       busy_q, flush_q;
    logic       own_v, own_l, room, push, rel;

    always_comb begin
        own_v = (state_q == GRANT0) ? req0_valid_i : (state_q == GRANT1) ? req1_valid_i : 1'b0;
        own_l = (state_q == GRANT0) ? req0_last_i : (state_q == GRANT1) ? req1_last_i : 1'b0;
        // A single free slot is only trusted if we did not just write into it
        room = (PUSH_FLAG >= 4'd2) || (PUSH_FLAG == 4'd1 && !prev_q);
        push = own_v && room;
        rel = push && (own_l || cnt_q == 8'(MAX_BURST - 1));
        PUSH = push;
        DIN = (state_q == GRANT0) ? req0_data_i : (state_q == GRANT1) ? req1_data_i : '0;
        req0_ready_o = push && state_q == GRANT0;
        req1_ready_o = push && state_q == GRANT1;
        Fifo_Push_Flush = flush_q;
        grant_o = grant_q;
        busy_o = busy_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        pend_d = pend_q;
        last_d = last_q;
        fcnt_d = fcnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req_i || pend_q) begin
                    state_d = FLUSH;
                    pend_d = 1'b0;
                    fcnt_d = 1'b0;
                end else if (req0_valid_i && (!req1_valid_i || last_q)) begin
                    state_d = GRANT0;
                    cnt_d = 8'd0;
                end else if (req1_valid_i) begin
                    state_d = GRANT1;
                    cnt_d = 8'd0;
                end
            end
            GRANT0, GRANT1: begin
                pend_d = pend_q | flush_req_i;
                cnt_d = push ? cnt_q + 8'd1 : cnt_q;
                if (rel) begin
                    state_d = IDLE;
                    last_d = state_q == GRANT1;
                end
            end
            FLUSH: begin
                fcnt_d = 1'b1;
                state_d = fcnt_q ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q <= IDLE;
            cnt_q <= 8'd0;
            pend_q <= 1'b0;
            last_q <= 1'b1;
            fcnt_q <= 1'b0;
            prev_q <= 1'b0;
            grant_q <= 2'b00;
            busy_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pend_q <= pend_d;
            last_q <= last_d;
            fcnt_q <= fcnt_d;
            prev_q <= push;
            grant_q <= {state_d == GRANT1, state_d == GRANT0};
            busy_q <= state_d != IDLE;
            flush_q <= state_d == FLUSH;
        end
    end
endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: directed scenarios plus random traffic against a cycle-level reference model.
module tb_fifo_push_arb;
    localparam int DW = 16;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0, fr = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic [3:0]    flag = 4'hF;
    logic          r0, r1, push, fpf, busy;
    logic [DW-1:0] din;
    logic [1:0]    grant;

    fifo_push_arb #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst),
        .req0_valid_i(v0), .req0_data_i(d0), .req0_last_i(l0), .req0_ready_o(r0),
        .req1_valid_i(v1), .req1_data_i(d1), .req1_last_i(l1), .req1_ready_o(r1),
        .flush_req_i(fr), .PUSH_FLAG(flag), .PUSH(push), .DIN(din),
        .Fifo_Push_Flush(fpf), .grant_o(grant), .busy_o(busy)
    );

    int n_cmp = 0, n_bad = 0;

    // reference model: owner 0 = none, 1 = req0, 2 = req1
    int owner = 0, burst = 0, flush_left = 0, rr_last = 2, e_own = 0;
    bit pend = 0, prev_push = 0, e_push = 0;
    logic o_push, o_fpf, o_busy, o_r0;
    logic [1:0] o_grant;

    int s0, s1, p0, p1, cnt, consec, fcnt, pbf;
    logic lastp;
    logic [1:0] first_g, second_g;
    logic [3:0] flags [4] = '{4'h0, 4'h1, 4'h2, 4'hF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; burst = 0; flush_left = 0; rr_last = 2; pend = 0; prev_push = 0;
    endtask

    task automatic cyc();
        logic ov, ol;
        @(negedge clk);
        ov = owner == 1 ? v0 : owner == 2 ? v1 : 1'b0;
        ol = owner == 1 ? l0 : owner == 2 ? l1 : 1'b0;
        e_own = owner;
        e_push = ov && (flag >= 4'd2 || (flag == 4'd1 && !prev_push));
        chk("push", push, e_push);
        chk("din", din, owner == 1 ? d0 : owner == 2 ? d1 : 0);
        chk("ready0", r0, e_push && owner == 1);
        chk("ready1", r1, e_push && owner == 2);
        chk("grant", grant, owner == 1 ? 1 : owner == 2 ? 2 : 0);
        chk("busy", busy, owner != 0 || flush_left != 0);
        chk("flush", fpf, flush_left != 0);
        o_push = push; o_grant = grant; o_fpf = fpf; o_busy = busy; o_r0 = r0;
        @(posedge clk);
        if (flush_left > 0) flush_left--;
        else if (owner == 0) begin
            if (fr || pend) begin flush_left = 2; pend = 0; end
            else if (v0 && v1) owner = (rr_last == 1) ? 2 : 1;
            else if (v0) owner = 1;
            else if (v1) owner = 2;
            burst = 0;
        end else begin
            if (fr) pend = 1;
            if (e_push) begin
                burst++;
                if (ol || burst == MB) begin rr_last = owner; owner = 0; end
            end
        end
        prev_push = e_push;
        #1;
    endtask

    initial begin
        v0 = 1'b1; v1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_push", push, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush", fpf, 0);
        chk("rst_din", din, 0);
        chk("rst_ready0", r0, 0);
        chk("rst_ready1", r1, 0);
        v0 = 1'b0; v1 = 1'b0; rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // both valid from reset: req0 3-word packet first, then req1
        s0 = 0; s1 = 0; p0 = 0; first_g = 0; second_g = 0;
        repeat (10) begin
            v0 = s0 < 3; d0 = 16'hA000 | 16'(s0); l0 = s0 == 2;
            v1 = s1 < 2; d1 = 16'hB000 | 16'(s1); l1 = s1 == 1; flag = 4'hF;
            cyc();
            if (e_push && e_own == 1) s0++;
            if (e_push && e_own == 2) s1++;
            if (o_grant != 0 && first_g == 0) first_g = o_grant;
            else if (o_grant != 0 && o_grant != first_g && second_g == 0) second_g = o_grant;
            if (o_push && o_grant == 2'b01) p0++;
        end
        chk("A_first_grant", first_g, 2'b01);
        chk("A_second_grant", second_g, 2'b10);
        chk("A_req0_pushes", p0, 3);

        // req0 never sends last: burst capped at MB, then req1 served
        s1 = 0; p0 = 0; p1 = 0;
        repeat (12) begin
            v0 = 1'b1; d0 = 16'($urandom); l0 = 1'b0;
            v1 = s1 < 2; d1 = 16'hC000 | 16'(s1); l1 = s1 == 1;
            cyc();
            if (e_push && e_own == 2) s1++;
            if (o_push && o_grant == 2'b01) p0++;
            if (o_push && o_grant == 2'b10) p1++;
        end
        chk("B_req0_burst", p0, MB);
        chk("B_req1_pushes", p1, 2);

        // one free slot: alternate-cycle pushes; full: nothing
        v0 = 1'b1; l0 = 1'b0; v1 = 1'b0; flag = 4'h1; cnt = 0; consec = 0; lastp = 1'b0;
        repeat (9) begin
            d0 = 16'($urandom);
            cyc();
            if (o_push) cnt++;
            if (o_push && lastp) consec++;
            lastp = o_push;
        end
        chk("C_alt_pushes", cnt, 4);
        chk("C_back_to_back", consec, 0);
        flag = 4'h0;
        repeat (3) begin
            cyc();
            chk("C_full_push", o_push, 0);
            chk("C_full_ready0", o_r0, 0);
        end
        flag = 4'hF; l0 = 1'b1;
        cyc();
        v0 = 1'b0; l0 = 1'b0;
        cyc();

        // flush mid-burst is deferred until the burst completes
        s0 = 0; p0 = 0; fcnt = 0; pbf = -1;
        for (int i = 0; i < 10; i++) begin
            v0 = s0 < 4; d0 = 16'hD000 | 16'(s0); l0 = s0 == 3; fr = i == 2;
            cyc();
            if (e_push && e_own == 1) s0++;
            if (o_push) p0++;
            if (o_fpf) fcnt++;
            if (o_fpf && pbf < 0) pbf = p0;
        end
        fr = 1'b0;
        chk("D_pushes", p0, 4);
        chk("D_pushes_before_flush", pbf, 4);
        chk("D_flush_cycles", fcnt, 2);
        chk("D_idle_after", o_busy, 0);

        // flush and valid together in IDLE: flush wins
        v0 = 1'b1; l0 = 1'b1; d0 = 16'hE001; fr = 1'b1; p0 = 0; fcnt = 0;
        cyc();
        fr = 1'b0;
        if (o_push) p0++;
        repeat (3) begin
            cyc();
            if (o_push) p0++;
            if (o_fpf) fcnt++;
        end
        chk("E_no_push_during_flush", p0, 0);
        chk("E_flush_cycles", fcnt, 2);
        cyc();
        chk("E_grant_after_flush", o_grant, 2'b01);
        chk("E_push_after_flush", o_push, 1);
        v0 = 1'b0; l0 = 1'b0;
        cyc();

        // async reset mid GRANT1 burst
        v1 = 1'b1; l1 = 1'b0; d1 = 16'hF00D;
        cyc();
        cyc();
        @(negedge clk); #1;
        chk("F_push_before_rst", push, 1);
        #2 rst = 1'b1;
        #1;
        chk("F_rst_push", push, 0);
        chk("F_rst_grant", grant, 0);
        chk("F_rst_ready1", r1, 0);
        chk("F_rst_busy", busy, 0);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        v0 = 1'b1; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1;
        cyc();
        cyc();
        chk("F_first_grant_after_rst", o_grant, 2'b01);
        v0 = 1'b0; v1 = 1'b0;
        repeat (3) cyc();

        // random traffic
        repeat (3000) begin
            v0 = $urandom_range(0, 3) != 0;
            v1 = $urandom_range(0, 3) != 0;
            l0 = $urandom_range(0, 3) == 0;
            l1 = $urandom_range(0, 3) == 0;
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            fr = $urandom_range(0, 15) == 0;
            flag = flags[$urandom_range(0, 3)];
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of each requester's data word and of DIN.
REQ-002 Parameter MAX_BURST, default 8, range 1-255, SHALL set the maximum words per grant.
REQ-003 Port WBs_CLK_i, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port WBs_RST_i, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Ports req0_valid_i and req1_valid_i, inputs, 1 bit each, SHALL mean the requester's word is presented.
REQ-006 Ports req0_data_i and req1_data_i, inputs, DATA_WIDTH each, SHALL carry the requester's data word.
REQ-007 Ports req0_last_i and req1_last_i, inputs, 1 bit each, SHALL mark the requester's final word of a packet.
REQ-008 Ports req0_ready_o and req1_ready_o, outputs, 1 bit each, SHALL mean the word is accepted this cycle.
REQ-009 Port flush_req_i, input, 1 bit, SHALL be a single-cycle pulse requesting a push-side FIFO flush.
REQ-010 Port PUSH_FLAG, input, 4 bits, SHALL carry the FIFO push-side status: 4'h0 = full, 4'h1 = exactly one free location, any other value = two or more free.
REQ-011 Port PUSH, output, 1 bit, SHALL be the FIFO write strobe.
REQ-012 Port DIN, output, DATA_WIDTH, SHALL be the FIFO write data.
REQ-013 Port Fifo_Push_Flush, output, 1 bit, SHALL be the FIFO push-side flush.
REQ-014 Port grant_o, output, 2 bits, SHALL be one-hot, showing the owner (bit0 = req0, bit1 = req1; 2'b00 = none).
REQ-015 Port busy_o, output, 1 bit, SHALL be high in any state other than IDLE.

Function
REQ-016 The state machine SHALL use four states: IDLE, GRANT0, GRANT1 and FLUSH.
REQ-017 IDLE: flush_req_i SHALL take priority and cause a transition to FLUSH.
REQ-018 IDLE: otherwise, a single valid requester SHALL be granted (transition to GRANT0 or GRANT1).
REQ-019 IDLE: when both requesters are valid, the grant SHALL go to the requester not granted last (round-robin); the first grant after reset SHALL go to req0.
REQ-020 The push condition SHALL be: owner valid AND (PUSH_FLAG >= 2, OR PUSH_FLAG == 1 with no PUSH in the previous cycle); this covers the flag-update latency.
REQ-021 The push SHALL be combinational: PUSH = push condition; DIN = owner data; owner ready = push condition; PUSH is never asserted while PUSH_FLAG == 0.
REQ-022 A burst counter of 8 bits SHALL clear on each grant and increment on each push.
REQ-023 The grant SHALL release to IDLE on a push with last = 1, or on a push that brings the counter to MAX_BURST; the released requester is recorded as last-granted.
REQ-024 Owner valid low mid-burst SHALL hold the grant with no push; there is no timeout.
REQ-025 flush_req_i during GRANT0 or GRANT1 SHALL be latched as pending, serviced on the next entry to IDLE, and SHALL NOT abort the burst.
REQ-026 FLUSH SHALL assert Fifo_Push_Flush for exactly 2 cycles, with no PUSH and no ready asserted, then return to IDLE.
REQ-027 A flush_req_i pulse arriving during FLUSH SHALL be ignored.
REQ-028 The non-owner's ready SHALL always be 0.
REQ-029 In IDLE and FLUSH, both readies SHALL be 0.
REQ-030 There SHALL be no zero-cycle grant: IDLE to GRANT costs one cycle, and the first push occurs at the earliest in the cycle after the grant decision.
REQ-031 The round-robin pointer SHALL update only on a completed release, not on a flush.

Reset
REQ-032 While WBs_RST_i is high, independent of the clock, the block SHALL hold: state = IDLE, grant_o = 2'b00, busy_o = 0, PUSH = 0, Fifo_Push_Flush = 0, DIN = 0, both readies = 0.
REQ-033 While WBs_RST_i is high, the block SHALL also hold: burst counter = 0, pending flush cleared, last-granted = req1 (so req0 wins first).
REQ-034 Reset asserted mid-burst or mid-flush SHALL abandon the operation immediately, with no further PUSH.

Verification
REQ-035 The bench SHALL check: both valid from reset, last on 3rd word, PUSH_FLAG = 4'hF -> grant_o = 01, 3 PUSH pulses with req0 data, then grant_o = 10.
REQ-036 The bench SHALL check: req0 streams with last never set, MAX_BURST = 8, req1 valid -> exactly 8 pushes, then req1 granted for its packet.
REQ-037 The bench SHALL check: PUSH_FLAG held 4'h1 with req0 valid continuously -> PUSH on alternate cycles only; PUSH_FLAG = 4'h0 -> no PUSH, ready0 = 0.
REQ-038 The bench SHALL check: flush_req_i pulsed mid-burst of 4 words -> all 4 pushed, then Fifo_Push_Flush high exactly 2 cycles, then IDLE.
REQ-039 The bench SHALL check: WBs_RST_i asserted asynchronously between clock edges during GRANT1 -> PUSH, grant_o and ready1 drop before the next edge; after release, the first grant goes to req0.
REQ-040 The bench SHALL check: flush_req_i and req0_valid_i in the same IDLE cycle -> FLUSH first, no PUSH for 2 cycles, then req0 granted.
